// File: rtl/vector_sync_pkg.sv
// Shared types and helpers for the vector_reg_sync source-side scheduler.
package vector_sync_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_t;

    // Width of the {toggle, id, data} vector, for sizing vector_reg_sync in the integrator.
    function automatic int unsigned out_width(input int unsigned n_req,
                                              input int unsigned data_w);
        return data_w + $clog2(n_req) + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap.
module rr_arbiter #(
    parameter  int unsigned pN_REQ = 4,
    localparam int unsigned pID_W  = $clog2(pN_REQ)
) (
    input  logic [pN_REQ-1:0] req,
    input  logic [pID_W-1:0]  ptr,
    output logic [pN_REQ-1:0] grant,
    output logic [pID_W-1:0]  grant_idx
);

    int unsigned      idx;
    logic [pID_W-1:0] idx_t;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        idx_t     = '0;
        for (int unsigned off = 1; off <= pN_REQ; off++) begin
            idx   = (32'(ptr) + off) % pN_REQ;
            idx_t = pID_W'(idx);
            if (!found && req[idx_t]) begin
                found        = 1'b1;
                grant[idx_t] = 1'b1;
                grant_idx    = idx_t;
            end
        end
    end

endmodule

// File: rtl/vector_sync_sched.sv
// Round-robin scheduler feeding one vector_reg_sync crossing; each word is held pHOLD cycles.
module vector_sync_sched
    import vector_sync_pkg::*;
#(
    parameter  int unsigned pN_REQ   = 4,
    parameter  int unsigned pDATA_W  = 16,
    parameter  int unsigned pHOLD    = 8,
    localparam int unsigned pID_W    = $clog2(pN_REQ),
    localparam int unsigned pOUT_W   = out_width(pN_REQ, pDATA_W)
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [pN_REQ-1:0]         req_valid,
    input  logic [pN_REQ*pDATA_W-1:0] req_data,
    output logic [pN_REQ-1:0]         req_ready,
    output logic [pOUT_W-1:0]         ovector,
    output logic                      busy
);

    localparam int unsigned pCNT_W = (pHOLD > 1) ? $clog2(pHOLD) : 1;

    sched_state_t        state_q, state_d;
    logic [pCNT_W-1:0]   cnt_q, cnt_d;
    logic [pID_W-1:0]    ptr_q, ptr_d;
    logic [pOUT_W-1:0]   ovector_q, ovector_d;

    logic [pN_REQ-1:0]   grant;
    logic [pID_W-1:0]    grant_idx;
    logic [pDATA_W-1:0]  sel_data;
    logic                can_grant;
    logic                transfer;

    rr_arbiter #(
        .pN_REQ (pN_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < pN_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*pDATA_W +: pDATA_W];
            end
        end
    end

    always_comb begin
        // Gating on rst keeps ready low while the async reset is asserted.
        can_grant = !rst && ((state_q == IDLE) || (cnt_q == '0));
        req_ready = can_grant ? grant : '0;
        transfer  = |(req_valid & req_ready);

        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        ovector_d = ovector_q;

        if (transfer) begin
            ovector_d = {~ovector_q[pOUT_W-1], grant_idx, sel_data};
            cnt_d     = pCNT_W'(pHOLD - 1);
            state_d   = HOLD;
            ptr_d     = grant_idx;
        end else if (state_q == HOLD) begin
            if (cnt_q == '0) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= pID_W'(pN_REQ - 1);
            ovector_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            ovector_q <= ovector_d;
        end
    end

    assign ovector = ovector_q;
    assign busy    = (state_q == HOLD);

endmodule

// File: tb/tb_vector_sync_sched.sv
// Self-checking bench for vector_sync_sched: arbitration table, directed corners, random vs model.
`timescale 1ns/1ps
module tb_vector_sync_sched;

    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 16;
    localparam int unsigned HOLD = 8;
    localparam int unsigned OW   = DW + 2 + 1;

    logic              clock = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_ready, valid2, ready2;
    logic [N*DW-1:0]   req_data, data2;
    logic [OW-1:0]     ovector, ovector2;
    logic              busy, busy2;

    always #5 clock = ~clock;

    vector_sync_sched #(
        .pN_REQ  (N),
        .pDATA_W (DW),
        .pHOLD   (HOLD)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ovector   (ovector),
        .busy      (busy)
    );

    vector_sync_sched #(
        .pN_REQ  (N),
        .pDATA_W (DW),
        .pHOLD   (1)
    ) dut_h1 (
        .clock     (clock),
        .rst       (rst),
        .req_valid (valid2),
        .req_data  (data2),
        .req_ready (ready2),
        .ovector   (ovector2),
        .busy      (busy2)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: last granted index, edges elapsed since the last transfer, output word.
    int            m_ptr;
    int            m_k;
    int            m_id;
    bit            m_tog;
    logic [DW-1:0] m_data;
    logic [N-1:0]  last_ready;

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] exp;
    } arb_vec_t;

    arb_vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = N - 1;
        m_k    = HOLD;
        m_tog  = 1'b0;
        m_id   = 0;
        m_data = '0;
    endtask

    function automatic int winner(input logic [N-1:0] v);
        for (int off = 1; off <= N; off++) begin
            int i;
            i = (m_ptr + off) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int w;
        w = winner(req_valid);
        if (rst || m_k < int'(HOLD) - 1 || w < 0) return '0;
        return N'(1) << w;
    endfunction

    function automatic logic [OW-1:0] m_ovec();
        logic [1:0] id;
        id = m_id[1:0];
        return {m_tog, id, m_data};
    endfunction

    // Called one unit after a rising edge; returns one unit after the next rising edge.
    task automatic tick(input bit drop);
        logic [N-1:0] er;
        int           w;
        #2;
        er = m_ready();
        w  = winner(req_valid);
        check("ready", req_ready, er);
        check("ovector", ovector, m_ovec());
        check("busy", busy, m_k < int'(HOLD));
        last_ready = req_ready;
        @(posedge clock);
        #1;
        if (er != '0) begin
            m_tog  = ~m_tog;
            m_id   = w;
            m_data = req_data[w*DW +: DW];
            m_ptr  = w;
            m_k    = 0;
            if (drop) req_valid[w] = 1'b0;
        end else if (m_k < int'(HOLD)) begin
            m_k++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clock);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int           bc;
        int           ch_t [$];
        logic [OW-1:0] ch_v [$];
        logic [OW-1:0] prev;

        tbl[0] = '{4'b0001, 4'b0001};
        tbl[1] = '{4'b0110, 4'b0010};
        tbl[2] = '{4'b1100, 4'b0100};
        tbl[3] = '{4'b1000, 4'b1000};
        tbl[4] = '{4'b1111, 4'b0001};
        tbl[5] = '{4'b1010, 4'b0010};
        tbl[6] = '{4'b0000, 4'b0000};
        tbl[7] = '{4'b0101, 4'b0001};

        rst = 1'b1;
        req_valid = '0;
        req_data  = '0;
        valid2    = '0;
        data2     = '0;
        model_reset();

        // Reset state, and no grant while rst is high even with requests pending.
        #2;
        check("rst_ovector", ovector, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_ovector_h1", ovector2, 0);
        req_valid = 4'hF;
        #1;
        check("ready_in_rst", req_ready, 0);
        req_valid = '0;
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;
        repeat (2) tick(1'b1);

        // Combinational arbitration from reset priority, no edge consumed.
        for (int i = 0; i < 8; i++) begin
            req_valid = tbl[i].v;
            #1;
            check($sformatf("arb_tbl%0d", i), req_ready, tbl[i].exp);
        end
        req_valid = '0;
        @(posedge clock);
        #1;

        // Single request from requester 2.
        req_data[2*DW +: DW] = 16'h1234;
        req_valid = 4'b0100;
        #1;
        check("single_ready", req_ready, 4'b0100);
        tick(1'b1);
        check("single_ovector", ovector, {1'b1, 2'd2, 16'h1234});
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) bc++;
            tick(1'b1);
        end
        check("single_busy_cycles", bc, 8);

        // All requesters continuously valid.
        do_reset();
        req_data  = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        req_valid = 4'hF;
        prev = ovector;
        for (int c = 1; c <= 33; c++) begin
            tick(1'b0);
            if (ovector !== prev) begin
                ch_t.push_back(c);
                ch_v.push_back(ovector);
                prev = ovector;
            end
        end
        check("cont_updates", ch_t.size(), 5);
        for (int i = 0; i < ch_t.size(); i++) begin
            check($sformatf("cont_id%0d", i), ch_v[i][17:16], i % 4);
            check($sformatf("cont_tog%0d", i), ch_v[i][18], (i % 2) == 0);
            check($sformatf("cont_data%0d", i), ch_v[i][15:0], 16'hAAAA + (i % 4) * 16'h1111);
            if (i > 0) check($sformatf("cont_space%0d", i), ch_t[i] - ch_t[i-1], 8);
        end
        req_valid = '0;

        // Request arriving mid-HOLD waits for the counter-0 cycle.
        do_reset();
        req_data[0 +: DW]  = 16'h0001;
        req_data[DW +: DW] = 16'h5555;
        req_valid = 4'b0001;
        tick(1'b1);
        for (int j = 1; j <= 8; j++) begin
            if (j == 3) req_valid[1] = 1'b1;
            tick(1'b1);
            check($sformatf("late_ready_j%0d", j), last_ready, (j == 8) ? 4'b0010 : 4'b0000);
        end
        check("late_ovector", ovector, {1'b0, 2'd1, 16'h5555});

        // Asynchronous reset in the middle of HOLD.
        do_reset();
        req_data[2*DW +: DW] = 16'hBEEF;
        req_valid = 4'b0100;
        tick(1'b1);
        repeat (4) tick(1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ovector", ovector, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", req_ready, 0);
        model_reset();
        @(posedge clock);
        #1;
        rst = 1'b0;
        req_data[3*DW +: DW] = 16'hC0DE;
        req_valid = 4'b1000;
        tick(1'b1);
        check("post_rst_ovector", ovector, {1'b1, 2'd3, 16'hC0DE});

        // Random traffic against the model.
        do_reset();
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    req_data[i*DW +: DW] = DW'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            tick(1'b1);
        end
        req_valid = '0;

        // pHOLD = 1: requesters 0 and 1 alternate every edge.
        data2  = {16'h0000, 16'h0000, 16'h2222, 16'h1111};
        valid2 = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            #2;
            check($sformatf("h1_ready%0d", i), ready2, ((i % 2) == 0) ? 4'b0001 : 4'b0010);
            @(posedge clock);
            #1;
            check($sformatf("h1_id%0d", i), ovector2[17:16], i % 2);
            check($sformatf("h1_tog%0d", i), ovector2[18], (i % 2) == 0);
            check($sformatf("h1_data%0d", i), ovector2[15:0], ((i % 2) == 0) ? 16'h1111 : 16'h2222);
            check($sformatf("h1_busy%0d", i), busy2, 1);
        end
        valid2 = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
